nor4_idle_qualifier: RTL and testbench
======================================

Name: nor4_idle_qualifier

Overview:
Sequential consumer of a 4-input NOR all-low detect. Registers four request/activity lines A1..A4 and forms their NOR internally. Asserts a qualified, glitch-filtered idle flag ZN only after the NOR has held high for HOLD consecutive enabled cycles. Emits single-cycle edge pulses for downstream power-gating and clock-gating control.

Parameters:
HOLD, 8, consecutive cycles the NOR must stay 1 before ZN asserts; legal range 1..(2^CNT_W)-1
CNT_W, 4, width of the qualification counter and of port QCNT

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous reset, active-high
EN  input  1  qualification enable; low forces BUSY
A1  input  1  activity line 1
A2  input  1  activity line 2
A3  input  1  activity line 3
A4  input  1  activity line 4
ZN  output  1  qualified idle flag: 1 = all inputs low for HOLD cycles
ZN_RISE  output  1  one-cycle pulse on the edge ZN goes 0->1
ZN_FALL  output  1  one-cycle pulse on the edge ZN goes 1->0
QCNT  output  CNT_W  current qualification count

Behaviour:
- Input stage: A1..A4 registered every edge into A_q (no reset dependency on function). raw = NOT(A1_q OR A2_q OR A3_q OR A4_q), combinational from A_q.
- Reset: RST=1 at an edge -> state BUSY, A_q=0, QCNT=0, ZN=0, ZN_RISE=0, ZN_FALL=0. Reset overrides all other inputs. Reset mid-QUAL or mid-IDLE aborts with no ZN_FALL pulse.
- All outputs registered. ZN_RISE and ZN_FALL default to 0 each cycle.
- FSM, evaluated at each edge with RST=0:
  - BUSY: ZN=0, QCNT=0. If EN and raw: when HOLD=1 -> IDLE, ZN=1, ZN_RISE=1; otherwise -> QUAL, QCNT=1. Else stay.
  - QUAL: ZN=0. If not EN or not raw -> BUSY, QCNT=0. Else if QCNT==HOLD-1 -> IDLE, ZN=1, ZN_RISE=1, QCNT=HOLD. Else QCNT+1.
  - IDLE: ZN=1, QCNT holds HOLD. If not EN or not raw -> BUSY, ZN=0, ZN_FALL=1, QCNT=0.
- Latency, inputs sampled all-low at edge 0 with EN=1:
  - A_q low after edge 0.
  - QUAL after edge 1.
  - ZN=1 and ZN_RISE=1 after edge HOLD. With HOLD=8, this is 9 edges from the first sampled all-low including edge 0.
- Release latency: any input sampled high at edge k -> ZN=0 and ZN_FALL=1 after edge k+1.
- A single-cycle input glitch during QUAL restarts qualification from BUSY. No partial-credit counting.
- The counter never wraps. It saturates at HOLD in IDLE.
- EN low while in IDLE produces exactly one ZN_FALL pulse. EN low while in BUSY or QUAL produces no pulse.
- ZN_RISE and ZN_FALL are never 1 in the same cycle.

Test Plan:
- RST=1 for 2 cycles with A=4'b1111 and EN=1, then release -> ZN=0, QCNT=0, no pulses during reset and the cycle after.
- HOLD=8, EN=1, A1..A4 driven 0 from edge 0 -> QCNT counts 1..7 over edges 1..7. ZN=1 and ZN_RISE=1 for exactly one cycle after edge 8; ZN stays 1 afterwards.
- In IDLE, A3 pulsed 1 for one cycle (sampled at edge k) -> ZN=0 and ZN_FALL=1 after edge k+1. Requalification takes another 8 edges.
- During QUAL at QCNT=5, A2 glitches high for one cycle -> return to BUSY with QCNT=0, no ZN_RISE. ZN rises only 8 edges after the inputs are clean again.
- EN toggled 0 for one cycle while in IDLE -> ZN_FALL single pulse, ZN=0. EN=0 while in QUAL -> QCNT=0 with no pulse.
- HOLD=1 build, inputs all-low -> BUSY goes straight to IDLE one edge after A_q goes low, with ZN_RISE=1 and QCNT=1. RST asserted while in IDLE -> ZN=0 with no ZN_FALL.

Source files
------------

// File: rtl/nor4_idle_qualifier_if.sv
// nor4_idle_qualifier_if: enable, activity lines and idle-flag outputs of the qualifier
interface nor4_idle_qualifier_if #(parameter int CNT_W = 4);
  logic             EN;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             A4;
  logic             ZN;
  logic             ZN_RISE;
  logic             ZN_FALL;
  logic [CNT_W-1:0] QCNT;
  modport master (output EN, A1, A2, A3, A4, input ZN, ZN_RISE, ZN_FALL, QCNT);
  modport slave  (input EN, A1, A2, A3, A4, output ZN, ZN_RISE, ZN_FALL, QCNT);
endinterface

// File: rtl/nor4_idle_qualifier.sv
// nor4_idle_qualifier: glitch-filtered 4-input NOR idle detect with edge pulses
module nor4_idle_qualifier #(
  parameter int HOLD  = 8,
  parameter int CNT_W = 4
) (
  input logic                  CLK,
  input logic                  RST,
  nor4_idle_qualifier_if.slave bus
);
  localparam logic [1:0] BUSY = 2'd0;
  localparam logic [1:0] QUAL = 2'd1;
  localparam logic [1:0] IDLE = 2'd2;
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  if (HOLD < 1 || HOLD >= (1 << CNT_W)) begin : g_bad_hold
    $error("HOLD out of range for CNT_W");
  end
  logic [1:0]       state_q, state_d;
  logic [3:0]       a_q;
  logic [CNT_W-1:0] qcnt_q, qcnt_d;
  logic             zn_q, zn_d, rise_q, rise_d, fall_q, fall_d;
  logic             raw, go;
  assign raw = ~|a_q;
  assign go  = bus.EN & raw;
  // next state: any break in EN or the NOR drops straight back to BUSY, no partial credit
  always_comb begin
    state_d = BUSY;
    qcnt_d  = '0;
    zn_d    = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      BUSY: begin
        state_d = go ? (HOLD == 1 ? IDLE : QUAL) : BUSY;
        qcnt_d  = go ? (HOLD == 1 ? HOLD_C : ONE_C) : '0;
        zn_d    = go && HOLD == 1;
        rise_d  = go && HOLD == 1;
      end
      QUAL: begin
        state_d = !go ? BUSY : (qcnt_q == LAST_C ? IDLE : QUAL);
        qcnt_d  = !go ? '0 : (qcnt_q == LAST_C ? HOLD_C : qcnt_q + ONE_C);
        zn_d    = go && qcnt_q == LAST_C;
        rise_d  = go && qcnt_q == LAST_C;
      end
      IDLE: begin
        state_d = go ? IDLE : BUSY;
        qcnt_d  = go ? HOLD_C : '0;
        zn_d    = go;
        fall_d  = !go;
      end
      default: state_d = BUSY;
    endcase
  end
  // state, input stage and registered outputs; reset aborts silently without a fall pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BUSY;
      a_q     <= '0;
      qcnt_q  <= '0;
      zn_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= {bus.A4, bus.A3, bus.A2, bus.A1};
      qcnt_q  <= qcnt_d;
      zn_q    <= zn_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign bus.ZN      = zn_q;
  assign bus.ZN_RISE = rise_q;
  assign bus.ZN_FALL = fall_q;
  assign bus.QCNT    = qcnt_q;
endmodule

// File: tb/tb_nor4_idle_qualifier.sv
// tb_nor4_idle_qualifier: scoreboard bench for HOLD=8 and HOLD=1 builds
module tb_nor4_idle_qualifier;
  typedef struct packed {
    logic       zn;
    logic       rise;
    logic       fall;
    logic [3:0] qcnt;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  nor4_idle_qualifier_if #(.CNT_W(4)) b8 ();
  nor4_idle_qualifier_if #(.CNT_W(4)) b1 ();
  nor4_idle_qualifier #(.HOLD(8), .CNT_W(4)) dut8 (.CLK(clk), .RST(rst), .bus(b8.slave));
  nor4_idle_qualifier #(.HOLD(1), .CNT_W(4)) dut1 (.CLK(clk), .RST(rst), .bus(b1.slave));
  obs_t       q8[$];
  obs_t       q1[$];
  int         run[2];
  logic       zp[2];
  logic [3:0] ap;
  int         n_assert = 0;
  int         n_fail = 0;
  function automatic obs_t get(input int k);
    obs_t o;
    o = k != 0 ? {b1.ZN, b1.ZN_RISE, b1.ZN_FALL, b1.QCNT} : {b8.ZN, b8.ZN_RISE, b8.ZN_FALL, b8.QCNT};
    return o;
  endfunction
  task automatic chk(input string tag, input obs_t o, input obs_t e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: got zn=%b rise=%b fall=%b qcnt=%0d, want zn=%b rise=%b fall=%b qcnt=%0d",
             tag, o.zn, o.rise, o.fall, o.qcnt, e.zn, e.rise, e.fall, e.qcnt);
    end
  endtask
  // Drive one cycle; the model counts consecutive enabled all-low samples of the previous input
  task automatic step(input logic r, input logic e, input logic [3:0] a, input string tag);
    obs_t x;
    int   h;
    rst = r;
    b8.EN = e;
    b1.EN = e;
    {b8.A4, b8.A3, b8.A2, b8.A1} = a;
    {b1.A4, b1.A3, b1.A2, b1.A1} = a;
    for (int k = 0; k < 2; k++) begin
      h = k != 0 ? 1 : 8;
      x = '0;
      if (r) run[k] = 0;
      else begin
        run[k] = (e && ap == 4'h0) ? (run[k] < h ? run[k] + 1 : h) : 0;
        x.zn   = run[k] >= h;
        x.rise = x.zn & ~zp[k];
        x.fall = ~x.zn & zp[k];
        x.qcnt = 4'(run[k]);
      end
      zp[k] = x.zn;
      if (k == 0) q8.push_back(x);
      else q1.push_back(x);
    end
    ap = r ? 4'h0 : a;
    @(posedge clk);
    #1;
    chk({tag, "/h8"}, get(0), q8.pop_front());
    chk({tag, "/h1"}, get(1), q1.pop_front());
    n_assert++;
    assert (!(b8.ZN_RISE && b8.ZN_FALL) && !(b1.ZN_RISE && b1.ZN_FALL)) else begin
      n_fail++;
      $error("FAIL %s/excl: rise8=%b fall8=%b rise1=%b fall1=%b, want no simultaneous pulses",
             tag, b8.ZN_RISE, b8.ZN_FALL, b1.ZN_RISE, b1.ZN_FALL);
    end
  endtask
  task automatic clean(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'h0, tag);
  endtask
  initial begin
    step(1'b1, 1'b1, 4'hF, "rst0");
    step(1'b1, 1'b1, 4'hF, "rst1");
    chk("rst_state", get(0), obs_t'(0));
    step(1'b0, 1'b0, 4'hF, "rel0");
    step(1'b0, 1'b1, 4'hF, "rel1");
    chk("rel_busy", get(0), obs_t'(0));
    step(1'b0, 1'b1, 4'h0, "edge0");
    step(1'b0, 1'b1, 4'h0, "edge1");
    chk("h1_rise", get(1), obs_t'{zn: 1'b1, rise: 1'b1, fall: 1'b0, qcnt: 4'd1});
    chk("h8_qual1", get(0), obs_t'{zn: 1'b0, rise: 1'b0, fall: 1'b0, qcnt: 4'd1});
    clean(6, "count");
    chk("h8_qual7", get(0), obs_t'{zn: 1'b0, rise: 1'b0, fall: 1'b0, qcnt: 4'd7});
    step(1'b0, 1'b1, 4'h0, "edge8");
    chk("h8_rise", get(0), obs_t'{zn: 1'b1, rise: 1'b1, fall: 1'b0, qcnt: 4'd8});
    clean(4, "sat");
    chk("h8_sat", get(0), obs_t'{zn: 1'b1, rise: 1'b0, fall: 1'b0, qcnt: 4'd8});
    step(1'b0, 1'b1, 4'b0100, "a3_pulse");
    step(1'b0, 1'b1, 4'h0, "a3_rel");
    chk("h8_fall", get(0), obs_t'{zn: 1'b0, rise: 1'b0, fall: 1'b1, qcnt: 4'd0});
    clean(10, "requal");
    step(1'b0, 1'b1, 4'b0010, "a2_busy");
    clean(6, "to_q5");
    chk("h8_q5", get(0), obs_t'{zn: 1'b0, rise: 1'b0, fall: 1'b0, qcnt: 4'd5});
    step(1'b0, 1'b1, 4'b0010, "glitch");
    clean(8, "post_glitch");
    chk("h8_no_early", get(0), obs_t'{zn: 1'b0, rise: 1'b0, fall: 1'b0, qcnt: 4'd7});
    clean(3, "glitch_idle");
    step(1'b0, 1'b0, 4'h0, "en_idle");
    chk("en_fall", get(0), obs_t'{zn: 1'b0, rise: 1'b0, fall: 1'b1, qcnt: 4'd0});
    clean(3, "en_qual");
    step(1'b0, 1'b0, 4'h0, "en_q");
    chk("en_q_nopulse", get(0), obs_t'(0));
    clean(10, "idle_again");
    step(1'b1, 1'b1, 4'h0, "rst_idle");
    chk("rst_nofall", get(1), obs_t'(0));
    step(1'b0, 1'b1, 4'h0, "rst_rel");
    for (int i = 0; i < 120; i++)
      step($urandom_range(0, 40) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0, "rand");
    clean(10, "tail");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
